router_link_tx: RTL and testbench

// - Upstream end of an inter-router link: sends flits into the neighbour's router_fifo input port.
// - Uses credit flow control. Keeps a count of free downstream FIFO slots. Drives the write strobe.

---
 rtl/router_pkg.sv | 13 +
 rtl/router_credit_counter.sv | 27 ++
 rtl/router_link_tx.sv | 62 ++++++
 tb/tb_router_link_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: flit framing types and link transmitter state shared by the router blocks
package router_pkg;
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;
  // Flit type sits in the top two bits; offsets are counted down from Width.
  localparam int FlitTypeMsb = 1;
  localparam int FlitTypeLsb = 2;
  typedef enum logic {TX_IDLE, TX_PKT} tx_state_t;
endpackage

// File: rtl/router_credit_counter.sv
// router_credit_counter: saturating free-slot counter that resets full
module router_credit_counter #(
  parameter int Max = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec,
  input  logic                       inc,
  output logic [$clog2(Max+1)-1:0]   count,
  output logic                       nonzero,
  output logic                       overflow
);
  localparam int W = $clog2(Max + 1);
  localparam logic [W-1:0] One = W'(1);
  localparam logic [W-1:0] Full = W'(Max);
  logic full;
  logic [W-1:0] count_d;
  always_comb begin
    full = count == Full;
    nonzero = count != '0;
    overflow = inc & ~dec & full;
    count_d = (dec & ~inc) ? count - One : (inc & ~dec & ~full) ? count + One : count;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= Full;
    else count <= count_d;
endmodule

// File: rtl/router_link_tx.sv
// router_link_tx: credit-flow-controlled link transmitter with packet framing tracking
module router_link_tx
  import router_pkg::*;
#(
  parameter int Width = 66,
  parameter int DownstreamDepth = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [Width-1:0]                       in_data,
  output logic                                   in_ready,
  output logic                                   link_wrreq,
  output logic [Width-1:0]                       link_data,
  input  logic                                   credit_in,
  output logic [$clog2(DownstreamDepth+1)-1:0]   credits,
  output logic                                   pkt_active,
  output logic                                   proto_err,
  output logic                                   credit_err
);
  logic xfer, nonzero, overflow, err;
  logic [1:0] ft;
  tx_state_t state, state_d;
  router_credit_counter #(.Max(DownstreamDepth)) u_credit (
    .clk(clk),
    .rst(rst),
    .dec(xfer),
    .inc(credit_in),
    .count(credits),
    .nonzero(nonzero),
    .overflow(overflow)
  );
  always_comb begin
    in_ready = nonzero;
    xfer = in_valid & nonzero;
    ft = in_data[Width-FlitTypeMsb:Width-FlitTypeLsb];
    state_d = (ft == FLIT_HEAD || (state == TX_PKT && ft == FLIT_BODY)) ? TX_PKT : TX_IDLE;
    err = (state == TX_IDLE) ? (ft == FLIT_BODY || ft == FLIT_TAIL)
                             : (ft == FLIT_HEAD || ft == FLIT_SINGLE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      link_wrreq <= 1'b0;
      link_data <= '0;
      state <= TX_IDLE;
      pkt_active <= 1'b0;
      proto_err <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      link_wrreq <= xfer;
      link_data <= xfer ? in_data : link_data;
      state <= xfer ? state_d : state;
      pkt_active <= xfer ? (state_d == TX_PKT) : pkt_active;
      proto_err <= proto_err | (xfer & err);
      credit_err <= credit_err | overflow;
    end
`ifndef SYNTHESIS
  a_credit_max: assert property (@(posedge clk) disable iff (!rst) credits <= DownstreamDepth);
  a_no_overrun: assert property (@(posedge clk) disable iff (!rst) link_wrreq |-> $past(credits) != 0);
  a_pkt_state:  assert property (@(posedge clk) disable iff (!rst) pkt_active == (state == TX_PKT));
`endif
endmodule

// File: tb/tb_router_link_tx.sv
// tb_router_link_tx: directed checks of credit flow, output register and framing
module tb_router_link_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [65:0] in_data = '0;
  logic in_ready, link_wrreq, credit_in, pkt_active, proto_err, credit_err;
  logic [65:0] link_data;
  logic [2:0] credits;
  int checks = 0;
  int errors = 0;
  router_link_tx #(.Width(66), .DownstreamDepth(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .link_wrreq(link_wrreq),
    .link_data(link_data),
    .credit_in(credit_in),
    .credits(credits),
    .pkt_active(pkt_active),
    .proto_err(proto_err),
    .credit_err(credit_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    credit_in = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (credits !== 3'd4 || in_ready !== 1'b1 || link_wrreq !== 1'b0 || link_data !== 66'd0 ||
        pkt_active !== 1'b0 || proto_err !== 1'b0 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: credits=%0d ready=%b wrreq=%b data=%h pkt=%b perr=%b cerr=%b, required 4 1 0 0 0 0 0",
               credits, in_ready, link_wrreq, link_data, pkt_active, proto_err, credit_err);
    end
    rst = 1'b1;
    step();
  endtask
  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data = {2'b11, 64'(i)};
      step();
      checks++;
      if (link_wrreq !== 1'b1 || link_data !== {2'b11, 64'(i)} || credits !== 3'(4 - i)) begin
        errors++;
        $display("FAIL fill%0d: wrreq=%b data=%h credits=%0d, required 1 %h %0d",
                 i, link_wrreq, link_data, credits, {2'b11, 64'(i)}, 4 - i);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL empty_ready: in_ready=%b, required 0", in_ready);
    end
    in_data = {2'b11, 64'h5};
    step();
    checks++;
    if (link_wrreq !== 1'b0 || link_data !== {2'b11, 64'h4} || credits !== 3'd0) begin
      errors++;
      $display("FAIL held: wrreq=%b data=%h credits=%0d, required 0 %h 0",
               link_wrreq, link_data, credits, {2'b11, 64'h4});
    end
  endtask
  task automatic test_credit_return();
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    checks++;
    if (credits !== 3'd1 || in_ready !== 1'b1 || link_wrreq !== 1'b0) begin
      errors++;
      $display("FAIL credit_ret: credits=%0d ready=%b wrreq=%b, required 1 1 0", credits, in_ready, link_wrreq);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (link_wrreq !== 1'b1 || link_data !== {2'b11, 64'h5} || credits !== 3'd0) begin
      errors++;
      $display("FAIL held_out: wrreq=%b data=%h credits=%0d, required 1 %h 0",
               link_wrreq, link_data, credits, {2'b11, 64'h5});
    end
  endtask
  task automatic test_simultaneous();
    credit_in = 1'b1;
    step();
    step();
    checks++;
    if (credits !== 3'd2) begin
      errors++;
      $display("FAIL two_credits: credits=%0d, required 2", credits);
    end
    in_valid = 1'b1;
    in_data = {2'b11, 64'h6};
    step();
    in_valid = 1'b0;
    checks++;
    if (credits !== 3'd2 || link_wrreq !== 1'b1 || link_data !== {2'b11, 64'h6}) begin
      errors++;
      $display("FAIL simul: credits=%0d wrreq=%b data=%h, required 2 1 %h",
               credits, link_wrreq, link_data, {2'b11, 64'h6});
    end
    step();
    step();
    credit_in = 1'b0;
    checks++;
    if (credits !== 3'd4 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL refill: credits=%0d cerr=%b, required 4 0", credits, credit_err);
    end
  endtask
  task automatic test_packet();
    logic [1:0] types [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    logic exp_pkt [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    credit_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = {types[i], 64'hA0 + 64'(i)};
      step();
      checks++;
      if (pkt_active !== exp_pkt[i] || proto_err !== 1'b0 || link_wrreq !== 1'b1 ||
          link_data !== {types[i], 64'hA0 + 64'(i)} || credits !== 3'd4) begin
        errors++;
        $display("FAIL packet%0d: pkt=%b perr=%b wrreq=%b data=%h credits=%0d, required %b 0 1 %h 4",
                 i, pkt_active, proto_err, link_wrreq, link_data, credits, exp_pkt[i],
                 {types[i], 64'hA0 + 64'(i)});
      end
    end
  endtask
  task automatic test_proto_err();
    logic [1:0] types [3] = '{2'b00, 2'b10, 2'b10};
    logic exp_pkt [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = {types[i], 64'hB0 + 64'(i)};
      step();
      checks++;
      if (proto_err !== 1'b1 || pkt_active !== exp_pkt[i] || link_wrreq !== 1'b1 ||
          link_data !== {types[i], 64'hB0 + 64'(i)}) begin
        errors++;
        $display("FAIL proto%0d: perr=%b pkt=%b wrreq=%b data=%h, required 1 %b 1 %h",
                 i, proto_err, pkt_active, link_wrreq, link_data, exp_pkt[i], {types[i], 64'hB0 + 64'(i)});
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic test_credit_err();
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    checks++;
    if (credits !== 3'd4 || credit_err !== 1'b1 || link_wrreq !== 1'b0) begin
      errors++;
      $display("FAIL credit_err: credits=%0d cerr=%b wrreq=%b, required 4 1 0", credits, credit_err, link_wrreq);
    end
    step();
    checks++;
    if (credit_err !== 1'b1 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky: cerr=%b perr=%b, required 1 1", credit_err, proto_err);
    end
  endtask
  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data = {2'b00, 64'hC0};
    step();
    in_valid = 1'b0;
    checks++;
    if (pkt_active !== 1'b1 || credits !== 3'd3) begin
      errors++;
      $display("FAIL mid_pkt: pkt=%b credits=%0d, required 1 3", pkt_active, credits);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (credits !== 3'd4 || pkt_active !== 1'b0 || proto_err !== 1'b0 || credit_err !== 1'b0 ||
        link_wrreq !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: credits=%0d pkt=%b perr=%b cerr=%b wrreq=%b ready=%b, required 4 0 0 0 0 1",
               credits, pkt_active, proto_err, credit_err, link_wrreq, in_ready);
    end
    step();
    rst = 1'b1;
    step();
  endtask
  initial begin
    test_reset();
    test_fill();
    test_credit_return();
    test_simultaneous();
    test_packet();
    test_proto_err();
    test_credit_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
